// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding for the TX and RX blocks
package uart_pkg;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    // 100 MHz system clock at 115200 baud
    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_IDLE,
        ST_START = UART_START,
        ST_DATA  = UART_DATA,
        ST_STOP  = UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, LSB first, registered serial line and done pulse
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tx_DV_in,
    input  logic [7:0] Tx_Byte_in,
    output logic       Tx_Serial_out,
    output logic       Tx_Active_out,
    output logic       Tx_Done_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $fatal(1, "uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    uart_state_t               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      serial_d, active_d, done_d;
    logic                      cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        byte_d  = byte_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (Tx_DV_in) begin
                    byte_d  = Tx_Byte_in;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line level is derived from the next state so every bit lasts exactly CLKS_PER_BIT cycles
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = byte_d[idx_d];
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            byte_q        <= '0;
            Tx_Serial_out <= 1'b1;
            Tx_Active_out <= 1'b0;
            Tx_Done_out   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            byte_q        <= byte_d;
            Tx_Serial_out <= serial_d;
            Tx_Active_out <= active_d;
            Tx_Done_out   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;
    localparam int MAXN  = 600;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Tx_DV_in = 1'b0;
    logic [7:0] Tx_Byte_in = 8'h00;
    logic       Tx_Serial_out;
    logic       Tx_Active_out;
    logic       Tx_Done_out;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Tx_DV_in     (Tx_DV_in),
        .Tx_Byte_in   (Tx_Byte_in),
        .Tx_Serial_out(Tx_Serial_out),
        .Tx_Active_out(Tx_Active_out),
        .Tx_Done_out  (Tx_Done_out)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    bit         st_dv   [MAXN];
    bit         st_rst  [MAXN];
    logic [7:0] st_byte [MAXN];
    logic [2:0] exp_out [MAXN];
    logic [2:0] got_out [MAXN];
    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            st_dv[i]   = 1'b0;
            st_rst[i]  = 1'b0;
            st_byte[i] = 8'($urandom);
        end
    endtask

    // Expected {serial, active, done} per cycle from the framing rules: a DV accepted at cycle t
    // owns cycles t+1..t+10C (start, 8 data LSB first, stop) and pulses done at t+10C+1.
    task automatic build_model(input int n);
        int free_at;
        int start;
        int bitpos;
        logic lvl;
        free_at = 0;
        start   = -1;
        exp_bytes.delete();
        for (int i = 0; i < MAXN; i++) exp_out[i] = 3'b100;
        for (int c = 0; c < n; c++) begin
            if (st_rst[c]) begin
                if (start >= 0 && c <= start + FRAME) void'(exp_bytes.pop_back());
                start = -1;
                for (int k = c + 1; k < MAXN; k++) exp_out[k] = 3'b100;
                free_at = c + 1;
            end else if (st_dv[c] && c >= free_at) begin
                start = c;
                exp_bytes.push_back(st_byte[c]);
                for (int k = 1; k <= FRAME; k++) begin
                    bitpos = (k - 1) / C;
                    if (bitpos == 0)      lvl = 1'b0;
                    else if (bitpos == 9) lvl = 1'b1;
                    else                  lvl = st_byte[c][bitpos-1];
                    exp_out[c+k] = {lvl, 1'b1, 1'b0};
                end
                exp_out[c+FRAME+1] = 3'b101;
                free_at = c + FRAME + 1;
            end
        end
    endtask

    task automatic run_window(input string name, input int n);
        int ndone;
        int s;
        logic [7:0] dec;
        build_model(n);
        for (int c = 0; c < n; c++) begin
            Tx_DV_in   = st_dv[c];
            Tx_Byte_in = st_byte[c];
            RST        = st_rst[c];
            got_out[c] = {Tx_Serial_out, Tx_Active_out, Tx_Done_out};
            check_eq($sformatf("%s cyc%0d serial/active/done", name, c), 32'(got_out[c]), 32'(exp_out[c]));
            @(posedge CLK);
            #1;
        end
        RST      = 1'b0;
        Tx_DV_in = 1'b0;

        // Decode each frame ending at a done pulse by sampling mid-bit
        got_bytes.delete();
        ndone = 0;
        for (int c = 0; c < n; c++) begin
            if (got_out[c][0]) begin
                s = c - FRAME;
                if (s >= 0) begin
                    for (int b = 0; b < 8; b++) dec[b] = got_out[s + (b + 1) * C + C / 2][2];
                    got_bytes.push_back(dec);
                    if (ndone < exp_bytes.size())
                        check_eq($sformatf("%s decoded byte %0d", name, ndone), 32'(dec), 32'(exp_bytes[ndone]));
                end
                ndone++;
            end
        end
        check_eq($sformatf("%s done pulse count", name), 32'(ndone), 32'(exp_bytes.size()));
    endtask

    initial begin
        int t;
        logic [15:0] result;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        clear_stim();
        for (int i = 0; i < 3; i++) st_rst[i] = 1'b1;
        run_window("reset_idle", 56);

        clear_stim();
        st_dv[0] = 1'b1; st_byte[0] = 8'hA5;
        run_window("single_a5", 50);

        clear_stim();
        st_dv[0] = 1'b1; st_byte[0] = 8'hFF;
        st_dv[FRAME+1] = 1'b1; st_byte[FRAME+1] = 8'h00;
        run_window("back_to_back", 100);

        clear_stim();
        st_dv[0] = 1'b1; st_byte[0] = 8'h3C;
        st_dv[10] = 1'b1; st_byte[10] = 8'h81;
        st_dv[20] = 1'b1; st_byte[20] = 8'h81;
        run_window("busy_ignore", 60);

        clear_stim();
        st_dv[0] = 1'b1; st_byte[0] = 8'h55;
        st_rst[15] = 1'b1;
        st_dv[30] = 1'b1; st_byte[30] = 8'h0F;
        run_window("reset_mid", 90);

        clear_stim();
        st_dv[5] = 1'b1; st_rst[5] = 1'b1; st_byte[5] = 8'h99;
        st_dv[10] = 1'b1; st_byte[10] = 8'h42;
        run_window("reset_priority", 60);

        for (int r = 0; r < 6; r++) begin
            clear_stim();
            result = 16'($urandom);
            st_dv[0] = 1'b1; st_byte[0] = result[15:8];
            st_dv[FRAME+1] = 1'b1; st_byte[FRAME+1] = result[7:0];
            run_window($sformatf("loopback%0d", r), 2 * FRAME + 10);
            if (got_bytes.size() == 2)
                check_eq($sformatf("loopback%0d result", r), 32'({got_bytes[0], got_bytes[1]}), 32'(result));
            else
                check_eq($sformatf("loopback%0d frames", r), 32'(got_bytes.size()), 32'd2);
        end

        for (int r = 0; r < 8; r++) begin
            clear_stim();
            t = $urandom_range(0, 5);
            while (t < 300 - FRAME - 6) begin
                st_dv[t] = 1'b1;
                st_dv[t + $urandom_range(1, FRAME)] = 1'b1;
                t = t + FRAME + 1 + $urandom_range(0, 3);
            end
            run_window($sformatf("random%0d", r), 300);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
